// File: rtl/regfile_checker.sv
// regfile_checker: runs the core for a fixed budget, then scans GPRs 1..31 against an expected ROM
module regfile_checker #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 29
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              proc_reset,
    output logic              proc_run,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_idx,
    output logic [DATA_W-1:0] fail_got,
    output logic [DATA_W-1:0] fail_exp
);
    localparam int RCE = RESET_CYCLES < 1 ? 1 : RESET_CYCLES;
    localparam int RNE = RUN_CYCLES < 1 ? 1 : RUN_CYCLES;
    localparam int MX = RCE > RNE ? RCE : RNE;
    localparam int CW = $clog2(MX + 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RCE - 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(RNE - 1);
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
    typedef enum logic [2:0] {IDLE, RST, RUN, SCAN, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic hit;
    assign exp_addr = rd_addr;
    assign hit = rd_data == exp_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            proc_reset <= 1'b1;
            proc_run   <= 1'b0;
            rd_addr    <= FIRST;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_idx   <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= RST;
                    cnt        <= '0;
                    proc_reset <= 1'b1;
                    proc_run   <= 1'b0;
                    rd_addr    <= FIRST;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    pass       <= 1'b0;
                    fail_idx   <= '0;
                    fail_got   <= '0;
                    fail_exp   <= '0;
                end
                RST: if (cnt == RST_LAST) begin
                    state      <= RUN;
                    cnt        <= '0;
                    proc_reset <= 1'b0;
                    proc_run   <= 1'b1;
                end else cnt <= cnt + 1'b1;
                RUN: if (cnt == RUN_LAST) begin
                    state    <= SCAN;
                    proc_run <= 1'b0;
                    rd_addr  <= FIRST;
                end else cnt <= cnt + 1'b1;
                SCAN: if (!hit) begin
                    state    <= DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    pass     <= 1'b0;
                    fail_idx <= rd_addr;
                    fail_got <= rd_data;
                    fail_exp <= exp_data;
                end else if (rd_addr == '1) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= 1'b1;
                end else rd_addr <= rd_addr + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_checker.sv
// tb_regfile_checker: stub regfile/ROM with a timeline model of the check sequence
module tb_regfile_checker;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic        proc_reset, proc_run, busy, done, pass;
    logic [4:0]  rd_addr, exp_addr, fail_idx;
    logic [31:0] rd_data, exp_data, fail_got, fail_exp;
    logic [31:0] regs [32];
    logic [31:0] rom [32];
    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    regfile_checker dut (
        .clk(clk), .reset(reset), .start(start), .proc_reset(proc_reset), .proc_run(proc_run),
        .rd_addr(rd_addr), .rd_data(rd_data), .exp_addr(exp_addr), .exp_data(exp_data),
        .busy(busy), .done(done), .pass(pass), .fail_idx(fail_idx), .fail_got(fail_got),
        .fail_exp(fail_exp)
    );

    assign rd_data  = regs[rd_addr];
    assign exp_data = rom[exp_addr];
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    function automatic int first_bad();
        for (int i = 1; i < 32; i++) if (regs[i] !== rom[i]) return i;
        return 0;
    endfunction

    // Model: time t counts edges since the accepted start; done lands at t = 31 + k
    bit m_act = 0, m_done = 0, m_pass = 0, s_pass = 0;
    int m_t = 0, s_k = 31, b;
    logic [4:0]  m_fi = 0, m_addr = 1;
    logic [31:0] m_fg = 0, m_fe = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_act <= 0; m_done <= 0; m_pass <= 0;
            m_fi <= 0; m_fg <= 0; m_fe <= 0; m_addr <= 5'd1;
        end else if (m_act) begin
            if (m_t + 1 == 31 + s_k) begin
                m_act  <= 0;
                m_done <= 1;
                m_pass <= s_pass;
                m_fi   <= s_pass ? 5'd0 : 5'(s_k);
                m_fg   <= s_pass ? 32'd0 : regs[s_k];
                m_fe   <= s_pass ? 32'd0 : rom[s_k];
                m_addr <= 5'(s_k);
            end else m_t <= m_t + 1;
        end else if (start) begin
            b = first_bad();
            m_act <= 1; m_t <= 0; m_done <= 0; m_pass <= 0;
            m_fi <= 0; m_fg <= 0; m_fe <= 0; m_addr <= 5'd1;
            s_k <= (b == 0) ? 31 : b;
            s_pass <= (b == 0);
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("proc_reset", proc_reset, m_act ? (m_t < 2) : !m_done);
        chk("proc_run", proc_run, m_act && m_t >= 2 && m_t <= 30);
        chk("busy", busy, m_act);
        chk("done", done, !m_act && m_done);
        chk("pass", pass, !m_act && m_pass);
        chk("rd_addr", rd_addr, m_act ? (m_t < 31 ? 32'd1 : 32'(m_t - 30)) : 32'(m_addr));
        chk("exp_addr", exp_addr, rd_addr);
        chk("fail_idx", fail_idx, m_act ? 5'd0 : m_fi);
        chk("fail_got", fail_got, m_act ? 32'd0 : m_fg);
        chk("fail_exp", fail_exp, m_act ? 32'd0 : m_fe);
    end

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin regs[i] = v; rom[i] = v; end
    endtask

    task automatic run_seq(input bit again, input int abort_at, output int ed, output int rc,
                           output int nc, output int mx);
        ed = -1; rc = 0; nc = 0; mx = 0;
        start = 1'b1;
        for (int e = 0; e < 300; e++) begin
            @(negedge clk);
            start = again && (e == 10 || e == 40);
            if (done) begin ed = e; break; end
            rc += int'(proc_reset);
            nc += int'(proc_run);
            if (int'(rd_addr) > mx) mx = int'(rd_addr);
            if (e == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("abort_proc_reset", proc_reset, 1);
                chk("abort_proc_run", proc_run, 0);
                chk("abort_busy", busy, 0);
                ed = e;
                return;
            end
        end
        if (ed < 0) chk("done_timeout", 0, 1);
    endtask

    int ed, rc, nc, mx;
    initial begin
        set_all(32'hcafebabe);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_proc_reset", proc_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_addr", rd_addr, 1);
        reset = 1'b0;
        @(negedge clk);
        run_seq(0, -1, ed, rc, nc, mx);
        chk("a_done_edge", ed, 62);
        chk("a_reset_cycles", rc, 2);
        chk("a_run_cycles", nc, 29);
        chk("a_pass", pass, 1);
        chk("a_fail_idx", fail_idx, 0);
        regs[7] = 32'h0000000d; rom[7] = 32'h00000015;
        @(negedge clk);
        run_seq(0, -1, ed, rc, nc, mx);
        chk("b_done_edge", ed, 38);
        chk("b_pass", pass, 0);
        chk("b_fail_idx", fail_idx, 7);
        chk("b_fail_got", fail_got, 32'h0000000d);
        chk("b_fail_exp", fail_exp, 32'h00000015);
        chk("b_max_addr", mx, 7);
        set_all(32'h12345678); regs[31] = 32'h0;
        run_seq(0, -1, ed, rc, nc, mx);
        chk("c_pass", pass, 0);
        chk("c_fail_idx", fail_idx, 31);
        set_all(32'h5a5a5a5a); regs[0] = 32'h1;
        run_seq(0, -1, ed, rc, nc, mx);
        chk("d_pass", pass, 1);
        chk("d_done_edge", ed, 62);
        set_all(32'hcafebabe);
        run_seq(1, -1, ed, rc, nc, mx);
        chk("e_done_edge", ed, 62);
        chk("e_reset_cycles", rc, 2);
        chk("e_run_cycles", nc, 29);
        run_seq(0, -1, ed, rc, nc, mx);
        chk("e_redo_edge", ed, 62);
        run_seq(0, 12, ed, rc, nc, mx);
        @(negedge clk);
        start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        chk("g_busy", busy, 0);
        chk("g_proc_reset", proc_reset, 1);
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 32; i++) begin rom[i] = $urandom; regs[i] = rom[i]; end
            for (int j = $urandom_range(0, 3); j > 0; j--)
                regs[$urandom_range(0, 31)] ^= 32'(1) << $urandom_range(0, 31);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_seq($urandom_range(0, 1) == 1, -1, ed, rc, nc, mx);
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
